// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath.
//   DefBitWidth  default component width (signed Q1.(W-1))
//   DefTagWidth  default width of the write-back tag
//   cplx_t       complex sample at the default width
//   sat_w1_to_w  clamps a sign-extended (W+1)-bit value into the signed W-bit range
package fft_pkg;

    localparam int unsigned DefBitWidth = 16;
    localparam int unsigned DefTagWidth = 10;

    typedef struct packed {
        logic signed [DefBitWidth-1:0] re;
        logic signed [DefBitWidth-1:0] im;
    } cplx_t;

    // The caller sign-extends its (width+1)-bit value to 33 bits and keeps the low
    // 'width' bits of the result. A constant 'width' lets synthesis fold the limits.
    function automatic logic [31:0] sat_w1_to_w(input logic signed [32:0] val,
                                                input int unsigned      width);
        logic signed [32:0] max_v;
        logic signed [32:0] min_v;
        max_v = (33'sd1 <<< (width - 1)) - 33'sd1;
        min_v = -(33'sd1 <<< (width - 1));
        if (val > max_v) begin
            return max_v[31:0];
        end else if (val < min_v) begin
            return min_v[31:0];
        end
        return val[31:0];
    endfunction

endpackage

// File: rtl/cmplxmult.sv
// Combinational complex multiplier: p = a * b for signed Q1.(W-1) operands.
// Each output component is bits [2W-2:W-1] of the full-precision result, i.e. the
// product rescaled to Q1.(W-1) and truncated toward -inf.
//   a_re, a_im  in   first operand
//   b_re, b_im  in   second operand
//   p_re, p_im  out  product
module cmplxmult #(
    parameter int unsigned BIT_WIDTH = 16
) (
    input  logic signed [BIT_WIDTH-1:0] a_re,
    input  logic signed [BIT_WIDTH-1:0] a_im,
    input  logic signed [BIT_WIDTH-1:0] b_re,
    input  logic signed [BIT_WIDTH-1:0] b_im,
    output logic        [BIT_WIDTH-1:0] p_re,
    output logic        [BIT_WIDTH-1:0] p_im
);

    localparam int unsigned PW = 2 * BIT_WIDTH;

    logic signed [PW-1:0] prod_rr;
    logic signed [PW-1:0] prod_ii;
    logic signed [PW-1:0] prod_ri;
    logic signed [PW-1:0] prod_ir;
    logic signed [PW:0]   full_re;
    logic signed [PW:0]   full_im;

    assign prod_rr = a_re * b_re;
    assign prod_ii = a_im * b_im;
    assign prod_ri = a_re * b_im;
    assign prod_ir = a_im * b_re;

    // One guard bit so the sum/difference of two products cannot wrap.
    assign full_re = $signed({prod_rr[PW-1], prod_rr}) - $signed({prod_ii[PW-1], prod_ii});
    assign full_im = $signed({prod_ri[PW-1], prod_ri}) + $signed({prod_ir[PW-1], prod_ir});

    // Low W bits after the shift are exactly bits [2W-2:W-1] of the full result.
    assign p_re = BIT_WIDTH'(full_re >>> (BIT_WIDTH - 1));
    assign p_im = BIT_WIDTH'(full_im >>> (BIT_WIDTH - 1));

endmodule

// File: rtl/fft_butterfly.sv
// Pipelined radix-2 DIT butterfly: A' = A + W*B, B' = A - W*B.
// Two register stages (operands, then results) with valid/ready flow control and a
// pass-through tag. Results are either halved (scale=1) or saturated (scale=0).
//   clk, reset             clock; synchronous active-low reset
//   in_valid, in_ready     operand handshake
//   a_*, b_*, w_*          operands A, B and twiddle W
//   scale                  1: halve results, 0: saturate
//   tag_in / tag_out       opaque tag returned with the result
//   out_valid, out_ready   result handshake
//   oa_*, ob_*             results A' and B'
module fft_butterfly
    import fft_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = DefBitWidth,
    parameter int unsigned TAG_WIDTH = DefTagWidth
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] a_re,
    input  logic [BIT_WIDTH-1:0] a_im,
    input  logic [BIT_WIDTH-1:0] b_re,
    input  logic [BIT_WIDTH-1:0] b_im,
    input  logic [BIT_WIDTH-1:0] w_re,
    input  logic [BIT_WIDTH-1:0] w_im,
    input  logic                 scale,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] oa_re,
    output logic [BIT_WIDTH-1:0] oa_im,
    output logic [BIT_WIDTH-1:0] ob_re,
    output logic [BIT_WIDTH-1:0] ob_im,
    output logic [TAG_WIDTH-1:0] tag_out
);

    localparam int unsigned W = BIT_WIDTH;

    // Stage 1: registered operands
    logic                 s1_valid_q;
    logic [W-1:0]         s1_a_re_q, s1_a_im_q;
    logic [W-1:0]         s1_b_re_q, s1_b_im_q;
    logic [W-1:0]         s1_w_re_q, s1_w_im_q;
    logic                 s1_scale_q;
    logic [TAG_WIDTH-1:0] s1_tag_q;

    // Stage 2: registered results, driven straight to the outputs
    logic                 s2_valid_q;
    logic [W-1:0]         s2_oa_re_q, s2_oa_im_q;
    logic [W-1:0]         s2_ob_re_q, s2_ob_im_q;
    logic [TAG_WIDTH-1:0] s2_tag_q;

    logic         advance1, advance2;
    logic [W-1:0] p_re, p_im;
    logic [W:0]   sum_re, sum_im, dif_re, dif_im;
    logic [W-1:0] oa_re_d, oa_im_d, ob_re_d, ob_im_d;

    // Halve (floor) or saturate one (W+1)-bit component.
    function automatic logic [W-1:0] finish(input logic [W:0] val, input logic halve);
        if (halve) begin
            return val[W:1];
        end
        return W'(sat_w1_to_w(33'(signed'(val)), W));
    endfunction

    cmplxmult #(
        .BIT_WIDTH(W)
    ) u_cmplxmult (
        .a_re (s1_b_re_q),
        .a_im (s1_b_im_q),
        .b_re (s1_w_re_q),
        .b_im (s1_w_im_q),
        .p_re (p_re),
        .p_im (p_im)
    );

    always_comb begin
        sum_re  = {s1_a_re_q[W-1], s1_a_re_q} + {p_re[W-1], p_re};
        sum_im  = {s1_a_im_q[W-1], s1_a_im_q} + {p_im[W-1], p_im};
        dif_re  = {s1_a_re_q[W-1], s1_a_re_q} - {p_re[W-1], p_re};
        dif_im  = {s1_a_im_q[W-1], s1_a_im_q} - {p_im[W-1], p_im};
        oa_re_d = finish(sum_re, s1_scale_q);
        oa_im_d = finish(sum_im, s1_scale_q);
        ob_re_d = finish(dif_re, s1_scale_q);
        ob_im_d = finish(dif_im, s1_scale_q);
    end

    // No skid buffer: ready ripples back combinationally from out_ready.
    assign advance2 = !s2_valid_q || out_ready;
    assign advance1 = !s1_valid_q || advance2;
    assign in_ready = advance1 || !reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_a_re_q  <= '0;
            s1_a_im_q  <= '0;
            s1_b_re_q  <= '0;
            s1_b_im_q  <= '0;
            s1_w_re_q  <= '0;
            s1_w_im_q  <= '0;
            s1_scale_q <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_oa_re_q <= '0;
            s2_oa_im_q <= '0;
            s2_ob_re_q <= '0;
            s2_ob_im_q <= '0;
            s2_tag_q   <= '0;
        end else begin
            if (advance1) begin
                s1_valid_q <= in_valid;
                // Operands are only captured with a valid, so idle inputs are ignored.
                if (in_valid) begin
                    s1_a_re_q  <= a_re;
                    s1_a_im_q  <= a_im;
                    s1_b_re_q  <= b_re;
                    s1_b_im_q  <= b_im;
                    s1_w_re_q  <= w_re;
                    s1_w_im_q  <= w_im;
                    s1_scale_q <= scale;
                    s1_tag_q   <= tag_in;
                end
            end
            if (advance2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_oa_re_q <= oa_re_d;
                    s2_oa_im_q <= oa_im_d;
                    s2_ob_re_q <= ob_re_d;
                    s2_ob_im_q <= ob_im_d;
                    s2_tag_q   <= s1_tag_q;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign oa_re     = s2_oa_re_q;
    assign oa_im     = s2_oa_im_q;
    assign ob_re     = s2_ob_re_q;
    assign ob_im     = s2_ob_im_q;
    assign tag_out   = s2_tag_q;

endmodule

// File: tb/tb_fft_butterfly.sv
// Directed bench for fft_butterfly: arithmetic vectors, backpressure and reset.
module tb_fft_butterfly;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic        scale;
    logic [9:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] oa_re, oa_im, ob_re, ob_im;
    logic [9:0]  tag_out;

    int n_checks = 0;
    int n_pass   = 0;

    fft_butterfly #(
        .BIT_WIDTH(16),
        .TAG_WIDTH(10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .scale     (scale),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .oa_re     (oa_re),
        .oa_im     (oa_im),
        .ob_re     (ob_re),
        .ob_im     (ob_im),
        .tag_out   (tag_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {out_valid, oa_re, oa_im, ob_re, ob_im, tag_out}
    function automatic logic [74:0] snap();
        return {out_valid, oa_re, oa_im, ob_re, ob_im, tag_out};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand set for one cycle; the pipeline must be empty and ready.
    task automatic issue(input logic [15:0] ar, input logic [15:0] ai,
                         input logic [15:0] br, input logic [15:0] bi,
                         input logic [15:0] wr, input logic [15:0] wi,
                         input logic sc, input logic [9:0] tg);
        in_valid = 1'b1;
        a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
        scale = sc; tag_in = tg;
        step();
        in_valid = 1'b0;
        a_re = 16'hDEAD; a_im = 16'hBEEF; b_re = 16'h1234; b_im = 16'h5678;
        w_re = 16'h7FFF; w_im = 16'h7FFF; scale = ~sc; tag_in = 10'h3FF;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
        scale = 1'b0; tag_in = '0;
        step();
        step();
        n_checks++;
        if (snap() !== 75'd0) $display("FAIL reset_state: got %h required 0", snap());
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
        else n_pass++;
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        issue(16'h4000, 16'h0, 16'h4000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 10'h011);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL basic_latency: out_valid %b required 0", out_valid);
        else n_pass++;
        step();
        n_checks++;
        if (snap() !== {1'b1, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 10'h011})
            $display("FAIL basic: got %h required %h", snap(),
                     {1'b1, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 10'h011});
        else n_pass++;
        step();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL basic_bubble: out_valid %b required 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_scaled();
        issue(16'h4000, 16'h0, 16'h4000, 16'h0, 16'h7FFF, 16'h0, 1'b1, 10'h022);
        step();
        n_checks++;
        if (snap() !== {1'b1, 16'h3FFF, 16'h0000, 16'h0000, 16'h0000, 10'h022})
            $display("FAIL scaled: got %h required %h", snap(),
                     {1'b1, 16'h3FFF, 16'h0000, 16'h0000, 16'h0000, 10'h022});
        else n_pass++;
        // Negative operand: -32768 - 16383 halves with floor to 0xA000.
        step();
        issue(16'h8000, 16'h0, 16'h4000, 16'h0, 16'h7FFF, 16'h0, 1'b1, 10'h023);
        step();
        n_checks++;
        if (snap() !== {1'b1, 16'hDFFF, 16'h0000, 16'hA000, 16'h0000, 10'h023})
            $display("FAIL scaled_neg: got %h required %h", snap(),
                     {1'b1, 16'hDFFF, 16'h0000, 16'hA000, 16'h0000, 10'h023});
        else n_pass++;
        step();
    endtask

    task automatic test_saturate();
        issue(16'h7000, 16'h0, 16'h7000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 10'h033);
        step();
        n_checks++;
        if (snap() !== {1'b1, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 10'h033})
            $display("FAIL saturate_pos: got %h required %h", snap(),
                     {1'b1, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 10'h033});
        else n_pass++;
        step();
        issue(16'h8000, 16'h0, 16'h4000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 10'h034);
        step();
        n_checks++;
        if (snap() !== {1'b1, 16'hBFFF, 16'h0000, 16'h8000, 16'h0000, 10'h034})
            $display("FAIL saturate_neg: got %h required %h", snap(),
                     {1'b1, 16'hBFFF, 16'h0000, 16'h8000, 16'h0000, 10'h034});
        else n_pass++;
        step();
    endtask

    task automatic test_twiddle();
        issue(16'h0, 16'h0, 16'h2000, 16'h0, 16'h0, 16'h8000, 1'b0, 10'h044);
        step();
        n_checks++;
        if (snap() !== {1'b1, 16'h0000, 16'hE000, 16'h0000, 16'h2000, 10'h044})
            $display("FAIL twiddle_minus_j: got %h required %h", snap(),
                     {1'b1, 16'h0000, 16'hE000, 16'h0000, 16'h2000, 10'h044});
        else n_pass++;
        step();
        // Both components non-zero: P = (0x3FFF, 0x3FFF).
        issue(16'h1000, 16'h2000, 16'h4000, 16'h4000, 16'h7FFF, 16'h0, 1'b0, 10'h045);
        step();
        n_checks++;
        if (snap() !== {1'b1, 16'h4FFF, 16'h5FFF, 16'hD001, 16'hE001, 10'h045})
            $display("FAIL complex_mix: got %h required %h", snap(),
                     {1'b1, 16'h4FFF, 16'h5FFF, 16'hD001, 16'hE001, 10'h045});
        else n_pass++;
        step();
    endtask

    task automatic test_backpressure();
        int          sent = 0;
        int          got = 0;
        logic        stalled = 1'b0;
        logic        saw_full = 1'b0;
        logic [74:0] held = '0;
        logic [73:0] exp_data;
        b_re = '0; b_im = '0; w_re = '0; w_im = '0; scale = 1'b0; a_im = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (got == 8 && sent == 8) break;
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (sent < 8);
            a_re      = 16'(sent * 256);
            tag_in    = 10'(sent);
            #1;
            if (stalled) begin
                n_checks++;
                if (snap() !== held)
                    $display("FAIL stall_stable: got %h required %h", snap(), held);
                else n_pass++;
            end
            if (out_valid && out_ready) begin
                exp_data = {16'(got * 256), 16'h0, 16'(got * 256), 16'h0, 10'(got)};
                n_checks++;
                if (snap() !== {1'b1, exp_data})
                    $display("FAIL stream_result%0d: got %h required %h", got, snap(),
                             {1'b1, exp_data});
                else n_pass++;
                got++;
            end
            if (in_valid && in_ready) sent++;
            if (!in_ready) saw_full = 1'b1;
            stalled = out_valid && !out_ready;
            held    = snap();
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (got != 8) $display("FAIL stream_count: got %0d results required 8", got);
        else n_pass++;
        n_checks++;
        if (saw_full !== 1'b1) $display("FAIL stream_in_ready: saw in_ready=0 %b required 1",
                                        saw_full);
        else n_pass++;
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL stream_no_dup: out_valid %b required 0",
                                         out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        logic seen_stale = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a_re = 16'h0100; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
        scale = 1'b0; tag_in = 10'h0AA;
        step();
        a_re = 16'h0200; tag_in = 10'h0BB;
        step();
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL midreset_in_ready: got %b required 1", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        n_checks++;
        if (snap() !== 75'd0) $display("FAIL midreset_clear: got %h required 0", snap());
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (out_valid !== 1'b0) seen_stale = 1'b1;
            step();
        end
        n_checks++;
        if (seen_stale !== 1'b0) $display("FAIL midreset_stale: stale seen %b required 0",
                                          seen_stale);
        else n_pass++;
        issue(16'h4000, 16'h0, 16'h4000, 16'h0, 16'h7FFF, 16'h0, 1'b0, 10'h155);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL midreset_latency: out_valid %b required 0",
                                         out_valid);
        else n_pass++;
        step();
        n_checks++;
        if (snap() !== {1'b1, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 10'h155})
            $display("FAIL midreset_fresh: got %h required %h", snap(),
                     {1'b1, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 10'h155});
        else n_pass++;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_scaled();
        test_saturate();
        test_twiddle();
        test_backpressure();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
